// File: rtl/mul_shift_unit_pkg.sv
// Shared definitions for the multiply/shift unit: operation codes,
// FSM state encodings and the default datapath width.
package mul_shift_unit_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    MUL_OP = 2'b00,
    SLL_OP = 2'b01,
    SRL_OP = 2'b10,
    ROR_OP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_t;

endpackage

// File: rtl/mul_shift_datapath.sv
// Datapath of the multiply/shift unit. It holds the 2*WIDTH accumulator,
// the multiplicand/multiplier shift registers and the shift-add adder.
// For shift operations only the low WIDTH bits of the accumulator are used
// as the working shift register; the high half stays zero.
module mul_shift_datapath
  import mul_shift_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             load_zero,
  input  logic             step,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  op_t                op;

  // Latch operands on load, then perform one shift-add or one-bit shift per step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op     <= MUL_OP;
    end else if (load) begin
      op     <= op_t'(select);
      mcand  <= {{WIDTH{1'b0}}, data1};
      mplier <= data2;
      if ((op_t'(select) == MUL_OP) || load_zero)
        acc <= '0;
      else
        acc <= {{WIDTH{1'b0}}, data1};
    end else if (step) begin
      case (op)
        MUL_OP: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        SLL_OP: acc <= {{WIDTH{1'b0}}, acc[WIDTH-2:0], 1'b0};
        SRL_OP: acc <= {{WIDTH{1'b0}}, 1'b0, acc[WIDTH-1:1]};
        ROR_OP: acc <= {{WIDTH{1'b0}}, acc[0], acc[WIDTH-1:1]};
        default: acc <= acc;
      endcase
    end
  end

  assign result   = acc[WIDTH-1:0];
  assign overflow = (op == MUL_OP) && (|acc[2*WIDTH-1:WIDTH]);

endmodule

// File: rtl/mul_shift_unit.sv
// Multi-cycle multiply/shift unit beside the execute-stage ALU.
// Holds the control FSM and iteration counter; the datapath does the math.
// RESULT, OVERFLOW and DONE are captured on the edge that leaves FINISH,
// so DONE is high during the cycle after FINISH.
module mul_shift_unit
  import mul_shift_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [1:0]       SELECT,
  input  logic             START,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERFLOW
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic             load;
  logic             load_zero;
  logic             step;
  logic [WIDTH-1:0] ror_amount;
  logic [WIDTH-1:0] dp_result;
  logic             dp_overflow;

  assign ror_amount = DATA2 % WIDTH_V;

  mul_shift_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock    (CLOCK),
    .reset    (RESET),
    .load     (load),
    .load_zero(load_zero),
    .step     (step),
    .select   (SELECT),
    .data1    (DATA1),
    .data2    (DATA2),
    .result   (dp_result),
    .overflow (dp_overflow)
  );

  // Next-state, counter and datapath control decoding.
  always_comb begin
    next_state = state;
    next_count = count;
    load       = 1'b0;
    load_zero  = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          load = 1'b1;
          case (op_t'(SELECT))
            MUL_OP: begin
              next_count = CNT_W'(WIDTH);
              next_state = RUN;
            end
            SLL_OP, SRL_OP: begin
              if (DATA2 >= WIDTH_V) begin
                load_zero  = 1'b1;
                next_state = FINISH;
              end else if (DATA2 == '0) begin
                next_state = FINISH;
              end else begin
                next_count = DATA2[CNT_W-1:0];
                next_state = RUN;
              end
            end
            ROR_OP: begin
              if (ror_amount == '0) begin
                next_state = FINISH;
              end else begin
                next_count = ror_amount[CNT_W-1:0];
                next_state = RUN;
              end
            end
            default: next_state = IDLE;
          endcase
        end
      end
      RUN: begin
        step       = 1'b1;
        next_count = count - 1'b1;
        if (count == CNT_W'(1))
          next_state = FINISH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, counter and registered outputs; reset discards any in-flight work.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      count    <= '0;
      RESULT   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      BUSY  <= (next_state == RUN);
      DONE  <= (state == FINISH);
      if (state == FINISH) begin
        RESULT   <= dp_result;
        OVERFLOW <= dp_overflow;
      end
    end
  end

endmodule

// File: tb/tb_mul_shift_unit.sv
// Self-checking bench for mul_shift_unit: directed cases, randomized
// operations against an arithmetic reference model, mid-operation
// interference, back-to-back START and asynchronous reset mid-multiply.
module tb_mul_shift_unit;

  localparam int WIDTH = 8;

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b0;
  logic [WIDTH-1:0] DATA1 = '0;
  logic [WIDTH-1:0] DATA2 = '0;
  logic [1:0]       SELECT = 2'b00;
  logic             START = 1'b0;
  logic [WIDTH-1:0] RESULT;
  logic             BUSY;
  logic             DONE;
  logic             OVERFLOW;

  int checks = 0;
  int passes = 0;

  mul_shift_unit #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .SELECT  (SELECT),
    .START   (START),
    .RESULT  (RESULT),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVERFLOW(OVERFLOW)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLOCK = ~CLOCK;

  // Reference model: plain arithmetic on the operation definitions.
  function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic o, output int lat);
    logic [15:0] p;
    int amt;
    o = 1'b0;
    case (op)
      2'd0: begin
        p   = 16'(a) * 16'(b);
        r   = p[7:0];
        o   = (p / 256) != 0;
        lat = WIDTH + 1;
      end
      2'd1, 2'd2: begin
        amt = int'(b);
        if (amt >= WIDTH) r = 8'h00;
        else if (op == 2'd1) r = a << amt;
        else r = a >> amt;
        lat = (amt == 0 || amt >= WIDTH) ? 1 : amt + 1;
      end
      default: begin
        amt = int'(b) % WIDTH;
        r   = (a >> amt) | (a << (WIDTH - amt));
        lat = (amt == 0) ? 1 : amt + 1;
      end
    endcase
  endfunction

  // Issue one START and wait (bounded) for DONE; lat = 0 means DONE never came.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busy_cnt,
                       output logic [7:0] res, output logic ovf);
    @(negedge CLOCK);
    SELECT = op; DATA1 = a; DATA2 = b; START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 2'($urandom);
    lat = 0;
    busy_cnt = BUSY ? 1 : 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge CLOCK);
      if (DONE) begin
        lat = e;
        break;
      end
      if (BUSY) busy_cnt++;
    end
    res = RESULT;
    ovf = OVERFLOW;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2;
    checks++;
    if ({RESULT, BUSY, DONE, OVERFLOW} !== 11'h000)
      $display("[TB] FAIL reset_outputs: got %h expected 000", {RESULT, BUSY, DONE, OVERFLOW});
    else passes++;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    checks++;
    if ({RESULT, BUSY, DONE, OVERFLOW} !== 11'h000)
      $display("[TB] FAIL post_reset_idle: got %h expected 000", {RESULT, BUSY, DONE, OVERFLOW});
    else passes++;
  endtask

  // Directed table shared by the multiply and shift tests.
  task automatic run_directed(input string name, input logic [1:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] exp_r,
                              input logic exp_o, input int exp_lat);
    int lat, busy_cnt;
    logic [7:0] res;
    logic ovf;
    do_op(op, a, b, lat, busy_cnt, res, ovf);
    checks++;
    if (res !== exp_r) $display("[TB] FAIL %s result: got %h expected %h", name, res, exp_r);
    else passes++;
    checks++;
    if (ovf !== exp_o) $display("[TB] FAIL %s overflow: got %b expected %b", name, ovf, exp_o);
    else passes++;
    checks++;
    if (lat != exp_lat) $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    else passes++;
    checks++;
    if (busy_cnt != exp_lat - 1) $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat - 1);
    else passes++;
    @(negedge CLOCK);
    checks++;
    if (DONE !== 1'b0) $display("[TB] FAIL %s done_pulse_width: got %b expected 0", name, DONE);
    else passes++;
    checks++;
    if (RESULT !== exp_r) $display("[TB] FAIL %s result_hold: got %h expected %h", name, RESULT, exp_r);
    else passes++;
  endtask

  task automatic test_mul();
    run_directed("mul_7x12",  2'd0, 8'h07, 8'h0C, 8'h54, 1'b0, 9);
    run_directed("mul_20x10", 2'd0, 8'h20, 8'h10, 8'h00, 1'b1, 9);
    run_directed("mul_ffxff", 2'd0, 8'hFF, 8'hFF, 8'h01, 1'b1, 9);
  endtask

  task automatic test_shift();
    run_directed("sll_07_3", 2'd1, 8'h07, 8'h03, 8'h38, 1'b0, 4);
    run_directed("srl_80_7", 2'd2, 8'h80, 8'h07, 8'h01, 1'b0, 8);
    run_directed("ror_81_1", 2'd3, 8'h81, 8'h01, 8'hC0, 1'b0, 2);
    run_directed("ror_81_8", 2'd3, 8'h81, 8'h08, 8'h81, 1'b0, 1);
    run_directed("sll_55_0", 2'd1, 8'h55, 8'h00, 8'h55, 1'b0, 1);
    run_directed("srl_ff_9", 2'd2, 8'hFF, 8'h09, 8'h00, 1'b0, 1);
  endtask

  task automatic test_random();
    int lat, busy_cnt, exp_lat;
    logic [7:0] res, a, b, exp_r;
    logic ovf, exp_o;
    logic [1:0] op;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = (op == 2'd0 || op == 2'd3) ? 8'($urandom) : 8'($urandom_range(0, 11));
      model(op, a, b, exp_r, exp_o, exp_lat);
      do_op(op, a, b, lat, busy_cnt, res, ovf);
      checks++;
      if (res !== exp_r || ovf !== exp_o)
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got %h/%b expected %h/%b", i, op, a, b, res, ovf, exp_r, exp_o);
      else passes++;
      checks++;
      if (lat != exp_lat)
        $display("[TB] FAIL random_%0d latency: got %0d expected %0d", i, lat, exp_lat);
      else passes++;
    end
  endtask

  task automatic test_ignore_midop();
    int lat;
    logic [7:0] exp_r;
    logic exp_o;
    int exp_lat;
    model(2'd0, 8'h0D, 8'h0B, exp_r, exp_o, exp_lat);
    @(negedge CLOCK);
    SELECT = 2'd0; DATA1 = 8'h0D; DATA2 = 8'h0B; START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge CLOCK);
      if (DONE) begin
        lat = e;
        break;
      end
      if (e == 3) begin
        START = 1'b1; DATA1 = 8'hFF; DATA2 = 8'hFF; SELECT = 2'd1;
      end
      if (e == 5) START = 1'b0;
    end
    START = 1'b0;
    checks++;
    if (RESULT !== exp_r || OVERFLOW !== exp_o)
      $display("[TB] FAIL midop_result: got %h/%b expected %h/%b", RESULT, OVERFLOW, exp_r, exp_o);
    else passes++;
    checks++;
    if (lat != exp_lat) $display("[TB] FAIL midop_latency: got %0d expected %0d", lat, exp_lat);
    else passes++;
    @(negedge CLOCK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0)
      $display("[TB] FAIL midop_no_requeue: got busy=%b done=%b expected 0/0", BUSY, DONE);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge CLOCK);
    SELECT = 2'd1; DATA1 = 8'h07; DATA2 = 8'h03; START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    repeat (3) @(negedge CLOCK);
    SELECT = 2'd3; DATA1 = 8'h81; DATA2 = 8'h01; START = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (DONE !== 1'b1 || RESULT !== 8'h38)
      $display("[TB] FAIL b2b_first_done: got done=%b result=%h expected 1/38", DONE, RESULT);
    else passes++;
    checks++;
    if (BUSY !== 1'b0) $display("[TB] FAIL b2b_start_in_finish_ignored: got busy=%b expected 0", BUSY);
    else passes++;
    @(negedge CLOCK);
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0)
      $display("[TB] FAIL b2b_accepted_in_idle: got busy=%b done=%b expected 1/0", BUSY, DONE);
    else passes++;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge CLOCK);
      if (DONE) begin
        lat = e;
        break;
      end
    end
    checks++;
    if (RESULT !== 8'hC0 || lat != 2)
      $display("[TB] FAIL b2b_second_op: got result=%h latency=%0d expected C0/2", RESULT, lat);
    else passes++;
  endtask

  task automatic test_reset_midop();
    int lat, busy_cnt, done_seen;
    logic [7:0] res;
    logic ovf;
    do_op(2'd0, 8'hFF, 8'hFF, lat, busy_cnt, res, ovf);
    @(negedge CLOCK);
    SELECT = 2'd0; DATA1 = 8'h33; DATA2 = 8'h44; START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    repeat (4) @(negedge CLOCK);
    checks++;
    if (BUSY !== 1'b1 || RESULT !== 8'h01 || OVERFLOW !== 1'b1)
      $display("[TB] FAIL rst_mid_pre: got busy=%b result=%h ovf=%b expected 1/01/1", BUSY, RESULT, OVERFLOW);
    else passes++;
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({RESULT, BUSY, DONE, OVERFLOW} !== 11'h000)
      $display("[TB] FAIL rst_mid_clear: got %h expected 000", {RESULT, BUSY, DONE, OVERFLOW});
    else passes++;
    @(negedge CLOCK);
    RESET = 1'b0;
    done_seen = 0;
    for (int e = 0; e < 15; e++) begin
      @(negedge CLOCK);
      if (DONE || BUSY) done_seen++;
    end
    checks++;
    if (done_seen != 0) $display("[TB] FAIL rst_mid_no_done: got %0d active cycles expected 0", done_seen);
    else passes++;
    do_op(2'd0, 8'h33, 8'h44, lat, busy_cnt, res, ovf);
    checks++;
    if (res !== 8'h8C || ovf !== 1'b1 || lat != 9)
      $display("[TB] FAIL rst_mid_next_op: got %h/%b lat=%0d expected 8c/1 lat=9", res, ovf, lat);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_shift();
    test_random();
    test_ignore_midop();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case the run gets stuck somewhere unexpected.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mul_shift_unit.md
Name: mul_shift_unit

Overview:
- Multi-cycle arithmetic unit that consumes the two register-file read ports, REGOUT1 and REGOUT2, as operands DATA1 and DATA2.
- Supports 8x8 multiply (low byte, plus overflow flag) and iterative SLL/SRL/ROR.
- RESULT feeds the register-file write-data mux. BUSY stalls PC update and register write until DONE.
- Sits beside the combinational ALU in the execute stage of the 8-bit processor.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CNT_W, 4, iteration counter width; must hold the value WIDTH.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- DATA1  input  WIDTH  operand A, from REGOUT1 (multiplicand, or value to shift).
- DATA2  input  WIDTH  operand B, from REGOUT2 (multiplier, or shift amount).
- SELECT  input  2  operation: 00 MUL, 01 SLL, 10 SRL, 11 ROR.
- START  input  1  request; sampled only in IDLE.
- RESULT  output  WIDTH  registered result; holds its value until the next DONE or RESET.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse when RESULT is updated.
- OVERFLOW  output  1  MUL: high byte of the 16-bit product is non-zero; shifts: 0. Updated with DONE.

Behaviour:
- Reset is asynchronous. On RESET high, all of the following take effect immediately, including mid-operation:
  - state = IDLE
  - RESULT = 0, BUSY = 0, DONE = 0, OVERFLOW = 0
  - internal accumulator, operand registers and counter cleared
  - any in-flight operation is discarded.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On an edge k with START = 1, latch DATA1, DATA2 and SELECT and clear the accumulator.
  - MUL: count = WIDTH; go to RUN.
  - SLL/SRL: if DATA2 >= WIDTH, load result 0 and go to FINISH. If DATA2 == 0, load DATA1 and go to FINISH. Otherwise count = DATA2 and go to RUN.
  - ROR: amount = DATA2 mod WIDTH. If amount is 0, load DATA1 and go to FINISH; otherwise go to RUN.
- RUN: one iteration per edge; count decrements; go to FINISH on the edge where count reaches 0.
  - MUL (shift-add): if multiplier LSB = 1, add multiplicand to the 16-bit accumulator; multiplicand shifts left, multiplier shifts right.
  - SLL: shift left 1, zero-fill.
  - SRL: shift right 1, zero-fill.
  - ROR: rotate right 1.
- FINISH: RESULT and OVERFLOW are registered and DONE = 1 for exactly one cycle. The next edge returns to IDLE.
- Latency, with START sampled at edge k:
  - MUL: DONE high from edge k+WIDTH+1 to k+WIDTH+2.
  - Shift by N (1..WIDTH-1): DONE from edge k+N+1.
  - Immediate cases (amount 0, or SLL/SRL amount >= WIDTH): DONE from edge k+1.
- BUSY = 1 exactly while the state is RUN.
- START is ignored in RUN and FINISH; no queuing. Operand or SELECT changes after edge k do not affect the operation in progress.
- Width rules:
  - MUL product is 2*WIDTH bits; RESULT = low WIDTH bits; OVERFLOW = |product[2*WIDTH-1:WIDTH].
  - Multiplication is unsigned. Two's-complement low byte is still correct for signed operands; OVERFLOW is unsigned only.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared header (included like the other lab files), holding:
  - SELECT encodings: MUL_OP, SLL_OP, SRL_OP, ROR_OP
  - state encodings: IDLE, RUN, FINISH
  - default WIDTH.
- One natural sub-module, mul_shift_datapath. It contains the accumulator, operand shift registers and adder, and takes op/load/step controls. The top level keeps the FSM and counter.

Test Plan:
- RESET pulse, then MUL 7 x 12 with START for one cycle -> BUSY for 8 cycles; DONE one cycle; RESULT = 0x54 (84); OVERFLOW = 0.
- MUL 0x20 x 0x10 -> RESULT = 0x00, OVERFLOW = 1. Then MUL 0xFF x 0xFF -> RESULT = 0x01, OVERFLOW = 1.
- SLL 0x07 by 3 -> DONE 4 edges after START; RESULT = 0x38. Then SRL 0x80 by 7 -> RESULT = 0x01, DONE after 8 edges.
- ROR 0x81 by 1 -> RESULT = 0xC0. ROR 0x81 by 8 and SLL 0x55 by 0 -> DONE at k+1 with RESULT = 0x81 / 0x55; SRL 0xFF by 9 -> RESULT = 0x00 at k+1.
- START pulsed again and DATA1/DATA2 changed mid-MUL -> ignored; the result matches the original operands. A back-to-back START in FINISH is ignored and accepted one cycle later in IDLE.
- RESET asserted between clock edges at iteration 4 of a MUL -> BUSY, DONE, RESULT and OVERFLOW go to 0 immediately. No DONE pulse follows; the next START runs normally.
